// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response, execute redirect and decode handshake.
// The master side is the fetch stage; the slave side is the surrounding pipeline and memory.
interface if_stage_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [63:0] id_pc;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: credit-limited fetch into a small in-order buffer, with redirect squashing.
// Optional stall counter enabled by defining IF_PERF_CNT_EN.
module if_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  if_stage_if.master        fetch_if
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);

  logic [63:0]   pc_q, pc_d;
  logic [63:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;

  logic [31:0]   instr_mem [BUF_DEPTH];
  logic [63:0]   pcbuf_mem [BUF_DEPTH];

  logic [CW:0]   occ;
  logic [63:0]   redir_target;
  logic          req;
  logic          grant;
  logic          rsp;
  logic          push;
  logic          drop;
  logic          valid;
  logic          pop;

  // Buffered plus in-flight words form the credit pool; same-cycle pops are deliberately not credited.
  assign occ          = {1'b0, count_q} + {1'b0, outst_q};
  assign redir_target = fetch_if.redirect_pc & ~64'h3;
  assign req          = !rst && !fetch_if.redirect && (occ < DEPTH_W);
  assign grant        = req && fetch_if.imem_gnt;
  assign rsp          = !rst && fetch_if.imem_rvalid && (outst_q != '0);
  assign push         = rsp && (drop_q == '0);
  assign drop         = rsp && (drop_q != '0);
  assign valid        = !rst && (count_q != '0);
  assign pop          = valid && fetch_if.id_ready;

  assign fetch_if.imem_req  = req;
  assign fetch_if.imem_addr = pc_q;
  assign fetch_if.id_valid  = valid;
  assign fetch_if.id_instr  = instr_mem[head_q];
  assign fetch_if.id_pc     = pcbuf_mem[head_q];

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    count_d   = count_q;
    outst_d   = outst_q;
    drop_d    = drop_q;
    head_d    = head_q;
    tail_d    = tail_q;

    if (grant) begin
      pc_d = pc_q + 64'd4;
    end

    case ({grant, rsp})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase

    if (push) begin
      resp_pc_d = resp_pc_q + 64'd4;
      tail_d    = tail_q + 1'b1;
    end
    if (drop) begin
      drop_d = drop_q - 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Everything still in flight after this cycle belongs to the old stream and must be discarded.
    if (fetch_if.redirect) begin
      pc_d      = redir_target;
      resp_pc_d = redir_target;
      count_d   = '0;
      head_d    = '0;
      tail_d    = '0;
      drop_d    = outst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      count_q   <= '0;
      outst_q   <= '0;
      drop_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_q] <= fetch_if.imem_rdata;
      pcbuf_mem[tail_q] <= resp_pc_q;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!valid && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_q;
`endif

  a_credit_bound: assert property (@(posedge clk) disable iff (rst) occ <= DEPTH_W);
  a_drop_bound:   assert property (@(posedge clk) disable iff (rst) drop_q <= outst_q);

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a queue-based memory and delivery model predicts every fetch and delivery.
// Build with IF_PERF_CNT_EN defined to also check the stall counter.
module tb_if_stage;

  localparam logic [63:0] RST_PC = 64'h0;
  localparam int          DEPTH  = 2;

  typedef struct {
    logic [63:0] addr;
    bit          stale;
    int          due;
  } flight_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_stage_if fe();
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
`endif

  if_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_if (fe)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  flight_t     inflight[$];
  logic [63:0] mbuf[$];
  logic [63:0] fetch_pc;
  logic [31:0] perf_exp;
  int          cyc;
  int          last_due;
  int          n_checks;
  int          n_errors;

  int p_gnt, p_ready, p_redir, max_lat;
  bit force_redir;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [63:0] pick_target();
    case ($urandom_range(4))
      0:       return 64'h100;
      1:       return 64'h203;
      2:       return 64'hFFFF_FFFF_FFFF_FFF8;
      3:       return 64'hFFFF_FFFF_FFFF_FFFC;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic run_cycles(input int n, input bit rst_v);
    for (int i = 0; i < n; i++) begin
      bit          rsp_now, exp_req, exp_valid, grant, pop;
      flight_t     f;
      int          due;
      @(negedge clk);
      rst            = rst_v;
      fe.imem_gnt    = ($urandom_range(99) < p_gnt);
      fe.id_ready    = ($urandom_range(99) < p_ready);
      fe.redirect    = !rst_v && (force_redir || ($urandom_range(99) < p_redir));
      fe.redirect_pc = pick_target();
      force_redir    = 1'b0;
      rsp_now        = !rst_v && (inflight.size() > 0) && (inflight[0].due <= cyc);
      fe.imem_rvalid = rsp_now;
      fe.imem_rdata  = rsp_now ? word_of(inflight[0].addr) : $urandom;
      #1;

      exp_req   = !rst_v && !fe.redirect && ((mbuf.size() + inflight.size()) < DEPTH);
      exp_valid = !rst_v && (mbuf.size() != 0);
      check_val("imem_req", 64'(fe.imem_req), 64'(exp_req));
      if (exp_req) check_val("imem_addr", fe.imem_addr, fetch_pc);
      check_val("id_valid", 64'(fe.id_valid), 64'(exp_valid));
      if (exp_valid) begin
        check_val("id_pc", fe.id_pc, mbuf[0]);
        check_val("id_instr", 64'(fe.id_instr), 64'(word_of(mbuf[0])));
        if (fe.id_ready) $display("deliver pc=%h instr=%h", fe.id_pc, fe.id_instr);
      end
`ifdef IF_PERF_CNT_EN
      check_val("perf_stall_cnt", 64'(perf_stall_cnt), 64'(perf_exp));
`endif

      if (rst_v) begin
        inflight.delete();
        mbuf.delete();
        fetch_pc = RST_PC;
        last_due = cyc;
        perf_exp = '0;
      end else begin
        if (!exp_valid && perf_exp != 32'hFFFF_FFFF) perf_exp++;
        grant = exp_req && fe.imem_gnt;
        pop   = exp_valid && fe.id_ready;
        if (rsp_now) f = inflight.pop_front();
        if (fe.redirect) begin
          mbuf.delete();
          foreach (inflight[k]) inflight[k].stale = 1'b1;
          fetch_pc = {fe.redirect_pc[63:2], 2'b00};
          $display("redirect to %h", fetch_pc);
        end else begin
          if (pop) void'(mbuf.pop_front());
          if (rsp_now && !f.stale) mbuf.push_back(f.addr);
          if (grant) begin
            due = cyc + int'($urandom_range(max_lat, 1));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            inflight.push_back('{addr: fetch_pc, stale: 1'b0, due: due});
            fetch_pc = fetch_pc + 64'd4;
          end
        end
      end
      cyc++;
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; last_due = 0;
    fetch_pc = RST_PC; perf_exp = '0; force_redir = 1'b0;
    rst = 1'b1;
    fe.imem_gnt = 1'b0; fe.imem_rvalid = 1'b0; fe.imem_rdata = '0;
    fe.redirect = 1'b0; fe.redirect_pc = '0; fe.id_ready = 1'b0;

    p_gnt = 100; p_ready = 100; p_redir = 0; max_lat = 1;
    run_cycles(3, 1'b1);
    run_cycles(30, 1'b0);              // streaming

    p_ready = 0;
    run_cycles(10, 1'b0);              // backpressure fills the buffer
    p_ready = 100;
    run_cycles(10, 1'b0);

    max_lat = 3;
    run_cycles(6, 1'b0);
    force_redir = 1'b1;                // redirect with responses pending
    run_cycles(12, 1'b0);

    p_gnt = 70; p_ready = 70; p_redir = 5; max_lat = 3;
    run_cycles(400, 1'b0);

    run_cycles(2, 1'b1);               // reset mid-stream
    p_gnt = 0; p_redir = 0;
    run_cycles(10, 1'b0);
    p_gnt = 80; p_ready = 60; p_redir = 4; max_lat = 4;
    run_cycles(300, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
